// File: rtl/hex_disp_arbiter_if.sv
// Display-sharing bus between two requesters and the seven-segment arbiter.
// master = requester/driver side, slave = arbiter side.
interface hex_disp_arbiter_if;
   logic        req_a;
   logic [15:0] hex_a;
   logic [3:0]  dp_a;
   logic        req_b;
   logic [15:0] hex_b;
   logic [3:0]  dp_b;
   logic        gnt_a;
   logic        gnt_b;
   logic [15:0] hex_out;
   logic [3:0]  dp_out;

   modport master (
      output req_a, hex_a, dp_a, req_b, hex_b, dp_b,
      input  gnt_a, gnt_b, hex_out, dp_out
   );

   modport slave (
      input  req_a, hex_a, dp_a, req_b, hex_b, dp_b,
      output gnt_a, gnt_b, hex_out, dp_out
   );
endinterface

// File: rtl/hex_disp_arbiter.sv
// Round-robin arbiter sharing one 4-digit seven-segment display between
// requesters A and B, with a minimum on-screen hold before preemption.
// All outputs are registered; hex/dp load from the next state's source.
module hex_disp_arbiter #(
   parameter int unsigned MIN_HOLD = 50_000_000,
   parameter int unsigned HOLD_W   = 26,
   parameter logic [3:0]  IDLE_DP  = 4'b1111
) (
   input  logic               clk,
   input  logic               reset,   // asynchronous, active low
   hex_disp_arbiter_if.slave  bus
);

   localparam logic [HOLD_W-1:0] HoldMax = HOLD_W'(MIN_HOLD - 1);
   localparam logic [HOLD_W-1:0] HoldOne = HOLD_W'(1);

   typedef enum logic [1:0] {StIdle, StOwnA, StOwnB} state_e;

   state_e            r_state, w_state_nxt;
   logic [HOLD_W-1:0] r_hold_cnt, w_hold_cnt_nxt;
   logic              r_last, w_last_nxt;      // 0 = A granted last, 1 = B
   logic [15:0]       r_hex, w_hex_nxt;
   logic [3:0]        r_dp, w_dp_nxt;
   logic              w_hold_done;

   assign w_hold_done = (r_hold_cnt >= HoldMax);

   // Next-state, hold counter, round-robin pointer and output data selection
   always_comb begin
      w_state_nxt    = r_state;
      w_hold_cnt_nxt = r_hold_cnt;
      w_last_nxt     = r_last;
      w_hex_nxt      = 16'h0000;
      w_dp_nxt       = IDLE_DP;

      unique case (r_state)
         StIdle: begin
            if (bus.req_a && bus.req_b) begin
               w_state_nxt = r_last ? StOwnA : StOwnB;
            end else if (bus.req_a) begin
               w_state_nxt = StOwnA;
            end else if (bus.req_b) begin
               w_state_nxt = StOwnB;
            end
         end
         StOwnA: begin
            // Voluntary release never waits for the hold time
            if (!bus.req_a) begin
               w_state_nxt = bus.req_b ? StOwnB : StIdle;
            end else if (bus.req_b && w_hold_done) begin
               w_state_nxt = StOwnB;
            end
         end
         StOwnB: begin
            if (!bus.req_b) begin
               w_state_nxt = bus.req_a ? StOwnA : StIdle;
            end else if (bus.req_a && w_hold_done) begin
               w_state_nxt = StOwnA;
            end
         end
         default: w_state_nxt = StIdle;
      endcase

      // Every ownership change restarts the hold window; staying saturates it
      if (w_state_nxt != r_state) begin
         w_hold_cnt_nxt = '0;
         if (w_state_nxt == StOwnA) begin
            w_last_nxt = 1'b0;
         end else if (w_state_nxt == StOwnB) begin
            w_last_nxt = 1'b1;
         end
      end else if (r_state != StIdle && !w_hold_done) begin
         w_hold_cnt_nxt = r_hold_cnt + HoldOne;
      end

      unique case (w_state_nxt)
         StOwnA: begin
            w_hex_nxt = bus.hex_a;
            w_dp_nxt  = bus.dp_a;
         end
         StOwnB: begin
            w_hex_nxt = bus.hex_b;
            w_dp_nxt  = bus.dp_b;
         end
         default: begin
            w_hex_nxt = 16'h0000;
            w_dp_nxt  = IDLE_DP;
         end
      endcase
   end

   // State and registered outputs; reset drops any grant without a clock edge
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= StIdle;
         r_hold_cnt <= '0;
         r_last     <= 1'b1;
         r_hex      <= 16'h0000;
         r_dp       <= IDLE_DP;
      end else begin
         r_state    <= w_state_nxt;
         r_hold_cnt <= w_hold_cnt_nxt;
         r_last     <= w_last_nxt;
         r_hex      <= w_hex_nxt;
         r_dp       <= w_dp_nxt;
      end
   end

   assign bus.gnt_a   = (r_state == StOwnA);
   assign bus.gnt_b   = (r_state == StOwnB);
   assign bus.hex_out = r_hex;
   assign bus.dp_out  = r_dp;

endmodule

// File: tb/tb_hex_disp_arbiter.sv
// Scoreboard bench for hex_disp_arbiter: directed scenarios then random
// traffic, checked against an ownership-level reference model.
module tb_hex_disp_arbiter;

   localparam int unsigned MinHold = 4;
   localparam int unsigned HoldW   = 3;
   localparam logic [3:0]  IdleDp  = 4'b1111;

   logic clk = 1'b0;
   logic rst_n;

   hex_disp_arbiter_if bus ();

   hex_disp_arbiter #(
      .MIN_HOLD (MinHold),
      .HOLD_W   (HoldW),
      .IDLE_DP  (IdleDp)
   ) u_dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ga;
      logic        gb;
      logic [15:0] hex;
      logic [3:0]  dp;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   // Reference model: owner 0 = none, 1 = A, 2 = B; held = cycles on screen
   int m_owner = 0;
   int m_last  = 2;
   int m_held  = 0;

   function automatic void chk(input string name, input logic [31:0] act,
                               input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
      end
   endfunction

   function automatic void model_edge(input logic r, input logic ra,
                                      input logic [15:0] ha, input logic [3:0] da,
                                      input logic rb, input logic [15:0] hb,
                                      input logic [3:0] db);
      exp_t e;
      int   prev;
      if (!r) begin
         m_owner = 0;
         m_last  = 2;
         m_held  = 0;
      end else begin
         prev = m_owner;
         if (m_owner == 0) begin
            if (ra && rb)  m_owner = (m_last == 2) ? 1 : 2;
            else if (ra)   m_owner = 1;
            else if (rb)   m_owner = 2;
         end else begin
            logic mine;
            logic other;
            mine  = (m_owner == 1) ? ra : rb;
            other = (m_owner == 1) ? rb : ra;
            if (!mine)                            m_owner = other ? 3 - m_owner : 0;
            else if (other && m_held >= MinHold)  m_owner = 3 - m_owner;
            else                                  m_held++;
         end
         if (m_owner != prev && m_owner != 0) begin
            m_held = 1;
            m_last = m_owner;
         end
      end
      e.ga  = (m_owner == 1);
      e.gb  = (m_owner == 2);
      e.hex = (m_owner == 1) ? ha : (m_owner == 2) ? hb : 16'h0000;
      e.dp  = (m_owner == 1) ? da : (m_owner == 2) ? db : IdleDp;
      exp_q.push_back(e);
   endfunction

   // Drive away from the edge, then predict what the edge produces
   task automatic step(input logic r, input logic ra, input logic [15:0] ha,
                       input logic [3:0] da, input logic rb,
                       input logic [15:0] hb, input logic [3:0] db);
      #3;
      rst_n     = r;
      bus.req_a = ra;
      bus.hex_a = ha;
      bus.dp_a  = da;
      bus.req_b = rb;
      bus.hex_b = hb;
      bus.dp_b  = db;
      @(posedge clk);
      model_edge(r, ra, ha, da, rb, hb, db);
   endtask

   // Monitor: the DUT presents fresh outputs after every edge
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("gnt_a", 32'(bus.gnt_a), 32'(e.ga));
         chk("gnt_b", 32'(bus.gnt_b), 32'(e.gb));
         chk("hex_out", 32'(bus.hex_out), 32'(e.hex));
         chk("dp_out", 32'(bus.dp_out), 32'(e.dp));
         chk("gnt_excl", 32'(bus.gnt_a & bus.gnt_b), 32'd0);
      end
   end

   initial begin
      logic ra, rb, r;
      rst_n     = 1'b0;
      bus.req_a = 1'b1;
      bus.hex_a = 16'h5A5A;
      bus.dp_a  = 4'b0101;
      bus.req_b = 1'b0;
      bus.hex_b = 16'h0000;
      bus.dp_b  = 4'b0000;

      // Reset held with A requesting: no grant, idle pattern
      repeat (3) step(1'b0, 1'b1, 16'h5A5A, 4'b0101, 1'b0, 16'h0, 4'h0);
      #2;
      chk("rst_gnt_a", 32'(bus.gnt_a), 32'd0);
      chk("rst_hex", 32'(bus.hex_out), 32'h0000);
      chk("rst_dp", 32'(bus.dp_out), 32'(IdleDp));
      step(1'b1, 1'b1, 16'h5A5A, 4'b0101, 1'b0, 16'h0, 4'h0);
      step(1'b1, 1'b0, 16'h5A5A, 4'b0101, 1'b0, 16'h0, 4'h0);

      // Tie from idle, then contended alternation
      for (int i = 0; i < 12; i++)
         step(1'b1, 1'b1, 16'h1234, 4'b0011, 1'b1, 16'hABCD, 4'b1100);

      // Voluntary release after 2 cycles of ownership
      step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0, 16'h0, 4'h0);
      repeat (2) step(1'b1, 1'b1, 16'h2222, 4'b0001, 1'b0, 16'h3333, 4'b0010);
      step(1'b1, 1'b0, 16'h2222, 4'b0001, 1'b1, 16'h3333, 4'b0010);
      step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0, 16'h0, 4'h0);

      // Uncontended B with ramping data, then A contends after saturation
      for (int i = 0; i < 20; i++)
         step(1'b1, 1'b0, 16'h0, 4'h0, 1'b1, 16'(i), 4'(i));
      repeat (2) step(1'b1, 1'b1, 16'h7777, 4'h7, 1'b1, 16'h0014, 4'h4);

      // Idle return
      repeat (2) step(1'b1, 1'b0, 16'h0, 4'h0, 1'b0, 16'h0, 4'h0);

      // Asynchronous reset while B owns
      repeat (3) step(1'b1, 1'b0, 16'h0, 4'h0, 1'b1, 16'hBEEF, 4'b1010);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_gnt_b", 32'(bus.gnt_b), 32'd0);
      chk("async_hex", 32'(bus.hex_out), 32'h0000);
      chk("async_dp", 32'(bus.dp_out), 32'(IdleDp));
      step(1'b0, 1'b1, 16'h4444, 4'h1, 1'b1, 16'hBEEF, 4'b1010);
      repeat (3) step(1'b1, 1'b1, 16'h4444, 4'h1, 1'b1, 16'hBEEF, 4'b1010);

      // Random traffic with sticky requests and rare resets
      ra = 1'b0;
      rb = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(7) == 0) ra = ~ra;
         if ($urandom_range(7) == 0) rb = ~rb;
         r = ($urandom_range(149) != 0);
         step(r, ra, 16'($urandom), 4'($urandom), rb, 16'($urandom), 4'($urandom));
      end

      // Let the monitor drain, bounded
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      #3;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
